// File: rtl/lat_seq_pkg.sv
// lat_seq_pkg: shared constants and state encoding for the latency sequencer.
// Optional max_lat tracking is built when LAT_SEQ_MAXLAT_EN is defined.
package lat_seq_pkg;

  localparam int VEC_W = 5;
  localparam int LAT_TIMEOUT_DEF = 255;
  localparam logic [7:0] LAT_TIMEOUT_CODE = 8'hFF;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_APPLY = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_DWELL = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/lat_seq_if.sv
// lat_seq_if: config/stimulus and result bundle between the sequencer,
// its controller (master) and the FSM under test.
interface lat_seq_if #(
  parameter int NUM_VEC = 8
) ();
  import lat_seq_pkg::*;

  localparam int AW = $clog2(NUM_VEC);

  logic             start;
  logic [7:0]       dwell;
  logic             vec_wr_en;
  logic [AW-1:0]    vec_wr_addr;
  logic [VEC_W-1:0] vec_wr_data;
  logic [7:0]       dut_out;
  logic [VEC_W-1:0] dut_in;
  logic             busy;
  logic             done;
  logic             lat_valid;
  logic [AW-1:0]    lat_idx;
  logic [7:0]       lat_cycles;
  logic             timeout_flag;
  logic [7:0]       max_lat;

  modport master (
    output start, dwell, vec_wr_en,
    output vec_wr_addr, vec_wr_data,
    output dut_out,
    input  dut_in, busy, done,
    input  lat_valid, lat_idx, lat_cycles,
    input  timeout_flag, max_lat
  );

  modport slave (
    input  start, dwell, vec_wr_en,
    input  vec_wr_addr, vec_wr_data,
    input  dut_out,
    output dut_in, busy, done,
    output lat_valid, lat_idx, lat_cycles,
    output timeout_flag, max_lat
  );

endinterface

// File: rtl/lat_seq_vec_rf.sv
// lat_seq_vec_rf: stimulus vector list, async clear,
// one write port and one combinational read port.
module lat_seq_vec_rf
  import lat_seq_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int AW      = $clog2(NUM_VEC)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [VEC_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [VEC_W-1:0] rdata_o
);

  logic [VEC_W-1:0] mem_q [NUM_VEC];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_VEC; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lat_seq_ctrl.sv
// lat_seq_ctrl: steps the FSM input through a vector list and measures
// response latency per vector. LAT_SEQ_MAXLAT_EN builds max_lat tracking.
module lat_seq_ctrl
  import lat_seq_pkg::*;
#(
  parameter int NUM_VEC     = 8,
  parameter int LAT_TIMEOUT = LAT_TIMEOUT_DEF
) (
  input  logic     clk_in,
  input  logic     reset_n,
  lat_seq_if.slave bus
);

  localparam int AW = $clog2(NUM_VEC);
  localparam logic [AW-1:0] LAST = AW'(NUM_VEC - 1);
  localparam logic [7:0] TO_LIM = 8'(LAT_TIMEOUT);

  state_t           st_q, st_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    lidx_q, lidx_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [7:0]       base_q, base_d;
  logic [7:0]       lat_q, lat_d;
  logic [VEC_W-1:0] din_q, din_d;
  logic [VEC_W-1:0] rd_vec;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lv_q, lv_d;
  logic             to_q, to_d;
  logic             start_acc;
  logic             hit;
  logic [7:0]       lat_nx;

  assign start_acc = (st_q == S_IDLE) && bus.start;
  assign hit = (st_q == S_WAIT) && (bus.dut_out != base_q);
  assign lat_nx = cnt_q + 8'd1;

  // list is frozen outside IDLE
  lat_seq_vec_rf #(.NUM_VEC(NUM_VEC)) u_rf (
    .clk_i   (clk_in),
    .rst_ni  (reset_n),
    .we_i    (bus.vec_wr_en && (st_q == S_IDLE)),
    .waddr_i (bus.vec_wr_addr),
    .wdata_i (bus.vec_wr_data),
    .raddr_i (idx_q),
    .rdata_o (rd_vec)
  );

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    lidx_d  = lidx_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    base_d  = base_q;
    lat_d   = lat_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lv_d    = 1'b0;
    to_d    = to_q;
    unique case (st_q)
      S_IDLE: begin
        if (start_acc) begin
          dwell_d = bus.dwell;
          idx_d   = '0;
          to_d    = 1'b0;
          busy_d  = 1'b1;
          st_d    = S_APPLY;
        end
      end
      S_APPLY: begin
        din_d  = rd_vec;
        base_d = bus.dut_out;
        cnt_d  = '0;
        st_d   = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = lat_nx;
        if (hit) begin
          lv_d   = 1'b1;
          lat_d  = lat_nx;
          lidx_d = idx_q;
          dcnt_d = '0;
          st_d   = S_DWELL;
        end else if (lat_nx == TO_LIM) begin
          lv_d   = 1'b1;
          lat_d  = LAT_TIMEOUT_CODE;
          lidx_d = idx_q;
          to_d   = 1'b1;
          dcnt_d = '0;
          st_d   = S_DWELL;
        end
      end
      S_DWELL: begin
        dcnt_d = dcnt_q + 8'd1;
        // dwell of 0 still spends one cycle here
        if ((dcnt_q + 8'd1) >= dwell_q) begin
          if (idx_q == LAST) begin
            done_d = 1'b1;
            st_d   = S_DONE;
          end else begin
            idx_d = idx_q + AW'(1);
            st_d  = S_APPLY;
          end
        end
      end
      S_DONE: begin
        din_d  = '0;
        busy_d = 1'b0;
        st_d   = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= S_IDLE;
      idx_q   <= '0;
      lidx_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      base_q  <= '0;
      lat_q   <= '0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      lidx_q  <= lidx_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      base_q  <= base_d;
      lat_q   <= lat_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lv_q    <= lv_d;
      to_q    <= to_d;
    end
  end

`ifdef LAT_SEQ_MAXLAT_EN
  logic [7:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (start_acc) max_d = '0;
    else if (hit && (lat_nx > max_q)) max_d = lat_nx;
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) max_q <= '0;
    else          max_q <= max_d;
  end

  assign bus.max_lat = max_q;
`else
  assign bus.max_lat = 8'h00;
`endif

  assign bus.dut_in       = din_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.lat_valid    = lv_q;
  assign bus.lat_idx      = lidx_q;
  assign bus.lat_cycles   = lat_q;
  assign bus.timeout_flag = to_q;

endmodule

// File: tb/tb_lat_seq_ctrl.sv
// tb_lat_seq_ctrl: table-driven sequences against a latency-programmable
// FSM model, plus busy-ignore and mid-run reset sequences.
module tb_lat_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lat_seq_if #(.NUM_VEC(8)) bus ();

  lat_seq_ctrl #(.NUM_VEC(8), .LAT_TIMEOUT(255)) dut (
    .clk_in  (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  // FSM model: output bumps mlat[v] cycles after input becomes v (0 = never)
  int         mlat [32];
  logic [4:0] m_prev = '0;
  int         m_pend = 0;

  always @(posedge clk) begin
    #1;
    if (bus.dut_in !== m_prev) begin
      m_prev = bus.dut_in;
      m_pend = mlat[bus.dut_in];
    end
    if (m_pend > 0) begin
      m_pend = m_pend - 1;
      if (m_pend == 0) bus.dut_out = bus.dut_out + 8'd1;
    end
  end

  int q_idx [$];
  int q_lat [$];
  int q_vin [$];
  int q_cyc [$];
  int done_cnt = 0;
  int done_cyc = 0;
  int t_start = 0;

  always @(negedge clk) begin
    if (bus.lat_valid === 1'b1) begin
      q_idx.push_back(int'(bus.lat_idx));
      q_lat.push_back(int'(bus.lat_cycles));
      q_vin.push_back(int'(bus.dut_in));
      q_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  typedef struct {
    logic [7:0] dw;
    int         lat [8];
  } tc_t;

  tc_t        tc [4];
  logic [4:0] v0 [8];
  logic [4:0] vz [8];
  int         l3 [8];
  int         lz [8];

  task automatic check(input string nm, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    q_idx.delete();
    q_lat.delete();
    q_vin.delete();
    q_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic program_vecs(input logic [4:0] v [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.vec_wr_en   = 1'b1;
      bus.vec_wr_addr = 3'(i);
      bus.vec_wr_data = v[i];
    end
    @(negedge clk);
    bus.vec_wr_en = 1'b0;
  endtask

  task automatic set_model(input logic [4:0] v [8], input int lt [8]);
    for (int i = 0; i < 8; i++) mlat[v[i]] = lt[i];
  endtask

  task automatic start_seq(input logic [7:0] dw);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dwell = dw;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dwell = 8'd77;
    t_start = cyc;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_seen"}, int'(done_cnt > 0), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    check({nm, "_dut_in"}, int'(bus.dut_in), 0);
    check({nm, "_busy"}, int'(bus.busy), 0);
    check({nm, "_done"}, int'(bus.done), 0);
    check({nm, "_lat_valid"}, int'(bus.lat_valid), 0);
    check({nm, "_lat_idx"}, int'(bus.lat_idx), 0);
    check({nm, "_lat_cycles"}, int'(bus.lat_cycles), 0);
    check({nm, "_timeout"}, int'(bus.timeout_flag), 0);
    check({nm, "_max_lat"}, int'(bus.max_lat), 0);
  endtask

  task automatic check_run(input string nm, input logic [7:0] dw,
                           input logic [4:0] v [8], input int lt [8]);
    int d;
    int t;
    int el;
    int emax;
    int eto;
    d = (dw == 8'd0) ? 1 : int'(dw);
    t = t_start + 1;
    emax = 0;
    eto = 0;
    check({nm, "_npulses"}, q_idx.size(), 8);
    for (int i = 0; i < 8; i++) begin
      el = (lt[i] == 0) ? 255 : lt[i];
      if (lt[i] == 0) eto = 1;
      else if (lt[i] > emax) emax = lt[i];
      t = t + el;
      if (i < q_idx.size()) begin
        check($sformatf("%s_idx%0d", nm, i), q_idx[i], i);
        check($sformatf("%s_lat%0d", nm, i), q_lat[i], el);
        check($sformatf("%s_vin%0d", nm, i), q_vin[i], int'(v[i]));
        check($sformatf("%s_t%0d", nm, i), q_cyc[i], t);
      end
      t = t + d + 1;
    end
    check({nm, "_done_cnt"}, done_cnt, 1);
    check({nm, "_done_t"}, done_cyc, t - 1);
    check({nm, "_timeout"}, int'(bus.timeout_flag), eto);
`ifdef LAT_SEQ_MAXLAT_EN
    check({nm, "_max_lat"}, int'(bus.max_lat), emax);
`else
    check({nm, "_max_lat"}, int'(bus.max_lat), 0);
`endif
    check({nm, "_busy_end"}, int'(bus.busy), 0);
    check({nm, "_dut_in_end"}, int'(bus.dut_in), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] va [8];
    int n;
    bus.start = 1'b0;
    bus.dwell = '0;
    bus.vec_wr_en = 1'b0;
    bus.vec_wr_addr = '0;
    bus.vec_wr_data = '0;
    bus.dut_out = 8'h5A;
    for (int i = 0; i < 32; i++) mlat[i] = 0;

    v0 = '{5'd1, 5'd8, 5'd16, 5'd3, 5'd10, 5'd22, 5'd7, 5'd14};
    vz = '{default: 5'd0};
    l3 = '{default: 3};
    lz = '{default: 0};
    tc[0].dw = 8'd4; tc[0].lat = '{3, 3, 3, 3, 3, 3, 3, 3};
    tc[1].dw = 8'd4; tc[1].lat = '{1, 5, 2, 3, 3, 3, 3, 3};
    tc[2].dw = 8'd2; tc[2].lat = '{2, 2, 2, 2, 0, 2, 2, 2};
    tc[3].dw = 8'd0; tc[3].lat = '{1, 2, 3, 4, 1, 2, 3, 4};

    repeat (3) @(negedge clk);
    chk_reset("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("rst_rel");

    for (int k = 0; k < 4; k++) begin
      program_vecs(v0);
      set_model(v0, tc[k].lat);
      clr();
      start_seq(tc[k].dw);
      wait_done($sformatf("tc%0d", k));
      check_run($sformatf("tc%0d", k), tc[k].dw, v0, tc[k].lat);
    end

    // same-cycle start + slot 0 write, then start/write while busy
    va = v0;
    va[0] = 5'd9;
    program_vecs(va);
    set_model(v0, l3);
    mlat[9] = 3;
    mlat[31] = 3;
    clr();
    @(negedge clk);
    bus.start = 1'b1;
    bus.dwell = 8'd4;
    bus.vec_wr_en = 1'b1;
    bus.vec_wr_addr = 3'd0;
    bus.vec_wr_data = 5'd1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.vec_wr_en = 1'b0;
    bus.dwell = 8'd77;
    t_start = cyc;
    repeat (20) @(negedge clk);
    bus.start = 1'b1;
    bus.dwell = 8'd0;
    bus.vec_wr_en = 1'b1;
    bus.vec_wr_addr = 3'd5;
    bus.vec_wr_data = 5'd31;
    @(negedge clk);
    bus.start = 1'b0;
    bus.vec_wr_en = 1'b0;
    bus.dwell = 8'd77;
    wait_done("busy_ign");
    check_run("busy_ign", 8'd4, v0, l3);
    repeat (40) @(negedge clk);
    check("busy_ign_npulses_late", q_idx.size(), 8);
    check("busy_ign_done_late", done_cnt, 1);
    check("busy_ign_busy_late", int'(bus.busy), 0);

    // reset during WAIT of vector 2
    program_vecs(v0);
    set_model(v0, l3);
    clr();
    start_seq(8'd4);
    n = 0;
    while (q_idx.size() < 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reach_v2", int'(q_idx.size() >= 2), 1);
    if (q_idx.size() >= 2) begin
      while (cyc < q_cyc[1] + 6) @(negedge clk);
    end
    check("midrst_busy_pre", int'(bus.busy), 1);
    check("midrst_dut_in_pre", int'(bus.dut_in), 16);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("midrst_rel");
    mlat[0] = 0;
    clr();
    start_seq(8'd1);
    wait_done("zerovec");
    check_run("zerovec", 8'd1, vz, lz);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
